// File: rtl/mem_bram_responder_pkg.sv
// Shared definitions for the BRAM responder: grant encoding, default base address
// and address-window helpers.
package mem_bram_responder_pkg;

    localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h2000_0000;

    typedef enum logic [2:0] {
        GNT_NONE = 3'd0,
        GNT_LOAD = 3'd1,
        GNT_WR   = 3'd2,
        GNT_DR   = 3'd3,
        GNT_IR   = 3'd4
    } gnt_e;

    // Span is 33 bits wide so a window reaching the top of the address space cannot wrap.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] span);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < span);
    endfunction

    function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/mem_bram_responder_if.sv
// Request/response bundle between the core/loader and the BRAM responder.
interface mem_bram_responder_if;
    logic        LOAD_EN;
    logic [31:0] LOAD_ADDR;
    logic [31:0] LOAD_DATA;
    logic        INST_RDEN;
    logic [31:0] INST_RIADDR;
    logic [31:0] INST_ROADDR;
    logic        INST_RVALID;
    logic [31:0] INST_RDATA;
    logic        DATA_RDEN;
    logic [31:0] DATA_RIADDR;
    logic [31:0] DATA_ROADDR;
    logic        DATA_RVALID;
    logic [31:0] DATA_RDATA;
    logic        DATA_WREN;
    logic [31:0] DATA_WADDR;
    logic [3:0]  DATA_WSTRB;
    logic [31:0] DATA_WDATA;
    logic        MEM_WAIT;
    logic        ADDR_ERR;

    modport slave (
        input  LOAD_EN, LOAD_ADDR, LOAD_DATA,
        input  INST_RDEN, INST_RIADDR,
        output INST_ROADDR, INST_RVALID, INST_RDATA,
        input  DATA_RDEN, DATA_RIADDR,
        output DATA_ROADDR, DATA_RVALID, DATA_RDATA,
        input  DATA_WREN, DATA_WADDR, DATA_WSTRB, DATA_WDATA,
        output MEM_WAIT, ADDR_ERR
    );

    modport master (
        output LOAD_EN, LOAD_ADDR, LOAD_DATA,
        output INST_RDEN, INST_RIADDR,
        input  INST_ROADDR, INST_RVALID, INST_RDATA,
        output DATA_RDEN, DATA_RIADDR,
        input  DATA_ROADDR, DATA_RVALID, DATA_RDATA,
        output DATA_WREN, DATA_WADDR, DATA_WSTRB, DATA_WDATA,
        input  MEM_WAIT, ADDR_ERR
    );
endinterface

// File: rtl/mem_bram_responder_bram_sp_bytewe.sv
// Single-port 32-bit RAM with per-byte write enables and a registered 1-cycle read.
// Contents are deliberately not reset so a loaded program survives a core reset.
module bram_sp_bytewe #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       strb,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [3:0][7:0] mem_r [DEPTH];
    logic [31:0]     rdata_r;

    // Byte-masked write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) begin
                        mem_r[idx][b] <= wdata[8*b +: 8];
                    end
                end
            end
            rdata_r <= mem_r[idx];
        end
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/mem_bram_responder.sv
// Arbitrates loader, data and instruction ports onto one single-port BRAM, with
// address-window checking and an instruction starvation boost.
module mem_bram_responder
    import mem_bram_responder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = DEFAULT_ADDR_BASE,
    parameter int          DEPTH_WORDS  = 4096,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    mem_bram_responder_if.slave  bus
);
    localparam int              IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0]     SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam int              CNT_W      = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(STARVE_LIMIT);

    gnt_e             gnt_s;
    logic             boost_s;
    logic             mem_wait_s;
    logic [31:0]      acc_addr_s;
    logic [31:0]      acc_wdata_s;
    logic [3:0]       acc_strb_s;
    logic             acc_in_range_s;
    logic             acc_is_read_s;
    logic             acc_is_write_s;
    logic             ram_en_s;
    logic             ram_we_s;
    logic [IDX_W-1:0] ram_idx_s;
    logic [31:0]      ram_q_s;

    logic [CNT_W-1:0] starve_cnt_r;
    logic             inst_valid_r;
    logic             data_valid_r;
    logic             rd_oor_r;
    logic [31:0]      inst_roaddr_r;
    logic [31:0]      data_roaddr_r;
    logic             addr_err_r;

    assign boost_s = (starve_cnt_r >= LIMIT_C);

    // Fixed-priority grant; a starved instruction fetch jumps ahead of data reads.
    always_comb begin
        gnt_s = GNT_NONE;
        if (RST) begin
            gnt_s = GNT_NONE;
        end else if (bus.LOAD_EN) begin
            gnt_s = GNT_LOAD;
        end else if (bus.DATA_WREN) begin
            gnt_s = GNT_WR;
        end else if (boost_s && bus.INST_RDEN) begin
            gnt_s = GNT_IR;
        end else if (bus.DATA_RDEN) begin
            gnt_s = GNT_DR;
        end else if (bus.INST_RDEN) begin
            gnt_s = GNT_IR;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Wait whenever any raised request lost arbitration this cycle.
    always_comb begin
        mem_wait_s = 1'b0;
        if (RST) begin
            mem_wait_s = 1'b0;
        end else begin
            mem_wait_s = (bus.LOAD_EN   && (gnt_s != GNT_LOAD)) ||
                         (bus.DATA_WREN && (gnt_s != GNT_WR))   ||
                         (bus.DATA_RDEN && (gnt_s != GNT_DR))   ||
                         (bus.INST_RDEN && (gnt_s != GNT_IR));
        end
    end

    // Route the granted requester onto the RAM port.
    always_comb begin
        acc_addr_s     = 32'h0000_0000;
        acc_wdata_s    = 32'h0000_0000;
        acc_strb_s     = 4'b0000;
        acc_is_read_s  = 1'b0;
        acc_is_write_s = 1'b0;
        case (gnt_s)
            GNT_LOAD: begin
                acc_addr_s     = bus.LOAD_ADDR;
                acc_wdata_s    = bus.LOAD_DATA;
                acc_strb_s     = 4'b1111;
                acc_is_write_s = 1'b1;
            end
            GNT_WR: begin
                acc_addr_s     = bus.DATA_WADDR;
                acc_wdata_s    = bus.DATA_WDATA;
                acc_strb_s     = bus.DATA_WSTRB;
                acc_is_write_s = 1'b1;
            end
            GNT_DR: begin
                acc_addr_s    = bus.DATA_RIADDR;
                acc_is_read_s = 1'b1;
            end
            GNT_IR: begin
                acc_addr_s    = bus.INST_RIADDR;
                acc_is_read_s = 1'b1;
            end
            default: begin
                acc_addr_s = 32'h0000_0000;
            end
        endcase
    end

    assign acc_in_range_s = addr_in_range(acc_addr_s, ADDR_BASE, SPAN_BYTES);
    assign ram_idx_s      = IDX_W'(word_offset(acc_addr_s, ADDR_BASE));
    assign ram_en_s       = (acc_is_read_s || acc_is_write_s) && acc_in_range_s;
    assign ram_we_s       = acc_is_write_s && acc_in_range_s;

    bram_sp_bytewe #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (CLK),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .strb  (acc_strb_s),
        .idx   (ram_idx_s),
        .wdata (acc_wdata_s),
        .rdata (ram_q_s)
    );

    // Response tracking aligned with the RAM read latency, plus the sticky range error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            inst_valid_r  <= 1'b0;
            data_valid_r  <= 1'b0;
            rd_oor_r      <= 1'b0;
            inst_roaddr_r <= 32'h0000_0000;
            data_roaddr_r <= 32'h0000_0000;
            addr_err_r    <= 1'b0;
        end else begin
            inst_valid_r <= (gnt_s == GNT_IR);
            data_valid_r <= (gnt_s == GNT_DR);
            if (acc_is_read_s) begin
                rd_oor_r <= !acc_in_range_s;
            end
            if (gnt_s == GNT_IR) begin
                inst_roaddr_r <= bus.INST_RIADDR;
            end
            if (gnt_s == GNT_DR) begin
                data_roaddr_r <= bus.DATA_RIADDR;
            end
            if ((acc_is_read_s || acc_is_write_s) && !acc_in_range_s) begin
                addr_err_r <= 1'b1;
            end
        end
    end

    // Starvation counter for instruction fetches, saturating at the boost threshold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt_r <= '0;
        end else if (!bus.INST_RDEN || (gnt_s == GNT_IR)) begin
            starve_cnt_r <= '0;
        end else if (starve_cnt_r < LIMIT_C) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end
    end

    // Outputs are masked by RST so a response falling due in a reset cycle is dropped.
    assign bus.INST_RVALID = inst_valid_r && !RST;
    assign bus.DATA_RVALID = data_valid_r && !RST;
    assign bus.INST_RDATA  = (inst_valid_r && !RST && !rd_oor_r) ? ram_q_s : 32'h0000_0000;
    assign bus.DATA_RDATA  = (data_valid_r && !RST && !rd_oor_r) ? ram_q_s : 32'h0000_0000;
    assign bus.INST_ROADDR = RST ? 32'h0000_0000 : inst_roaddr_r;
    assign bus.DATA_ROADDR = RST ? 32'h0000_0000 : data_roaddr_r;
    assign bus.ADDR_ERR    = addr_err_r && !RST;
    assign bus.MEM_WAIT    = mem_wait_s;
endmodule
